// File: rtl/bird_motion_ctrl.sv
// Bird sprite sequencer: walks the datapath through draw/erase/move/check once per
// frame step, across the fly, fall and flee phases of a round.
module bird_motion_ctrl #(
    parameter int         TICK_DIV        = 833333,
    parameter int         FLY_STEP_FRAMES = 4,
    parameter int         DIR_HOLD_FRAMES = 32,
    parameter int         ESCAPE_FRAMES   = 600,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic       draw_done,
    input  logic       shot,
    input  logic       flying,
    output logic [3:0] control,
    output logic       active,
    output logic       hit,
    output logic       escaped
);
    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int STEP_W = $clog2(FLY_STEP_FRAMES + 1);
    localparam int DIRC_W = $clog2(DIR_HOLD_FRAMES + 1);
    localparam int ESC_W  = $clog2(ESCAPE_FRAMES + 1);

    localparam logic [3:0] OP_HOLD    = 4'd0;
    localparam logic [3:0] OP_LEFT    = 4'd1;
    localparam logic [3:0] OP_RIGHT   = 4'd2;
    localparam logic [3:0] OP_UP      = 4'd3;
    localparam logic [3:0] OP_DOWN    = 4'd4;
    localparam logic [3:0] OP_CLEAR   = 4'd5;
    localparam logic [3:0] OP_DRAW    = 4'd6;
    localparam logic [3:0] OP_SHOT    = 4'd7;
    localparam logic [3:0] OP_ESCAPE  = 4'd8;
    localparam logic [3:0] OP_CHECK   = 4'd9;
    localparam logic [3:0] OP_PREHOLD = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAW0, S_WAIT, S_ERASE, S_MOVE, S_DRAW, S_CHECK, S_DONE
    } state_t;

    typedef enum logic [1:0] {M_FLY, M_FALL, M_FLEE} mode_t;

    state_t              state_reg;
    mode_t               mode_reg;
    logic [1:0]          dir_reg;
    logic [DIV_W-1:0]    div_reg;
    logic [STEP_W-1:0]   step_reg;
    logic [DIRC_W-1:0]   dirc_reg;
    logic [ESC_W-1:0]    esc_reg;
    logic [7:0]          lfsr_reg;
    logic                tick_pend_reg;

    logic tick;
    logic lfsr_fb;
    logic consume;
    logic step_now;
    logic esc_due;

    assign tick     = (div_reg == DIV_W'(TICK_DIV - 1));
    assign lfsr_fb  = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    assign consume  = (state_reg == S_WAIT) && tick_pend_reg;
    assign step_now = consume &&
                      ((mode_reg != M_FLY) || (step_reg == STEP_W'(FLY_STEP_FRAMES - 1)));
    assign esc_due  = (esc_reg >= ESC_W'(ESCAPE_FRAMES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            mode_reg      <= M_FLY;
            dir_reg       <= '0;
            div_reg       <= '0;
            step_reg      <= '0;
            dirc_reg      <= '0;
            esc_reg       <= '0;
            lfsr_reg      <= LFSR_SEED;
            tick_pend_reg <= 1'b0;
        end else begin
            div_reg <= tick ? '0 : div_reg + 1'b1;
            if (tick)
                lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
            // A tick landing while one is already pending is dropped, not queued.
            if (consume)
                tick_pend_reg <= 1'b0;
            else if (tick)
                tick_pend_reg <= 1'b1;
            if (tick && (mode_reg == M_FLY) && (state_reg != S_IDLE) && !esc_due)
                esc_reg <= esc_reg + 1'b1;

            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        mode_reg  <= M_FLY;
                        step_reg  <= '0;
                        dirc_reg  <= '0;
                        esc_reg   <= '0;
                        dir_reg   <= lfsr_reg[1:0];
                        state_reg <= S_DRAW0;
                    end
                end
                S_DRAW0: if (draw_done) state_reg <= S_WAIT;
                S_WAIT: begin
                    if (step_now) begin
                        step_reg  <= '0;
                        state_reg <= S_ERASE;
                    end else if (consume) begin
                        step_reg <= step_reg + 1'b1;
                    end
                end
                S_ERASE: if (draw_done) state_reg <= S_MOVE;
                S_MOVE:  state_reg <= S_DRAW;
                S_DRAW:  if (draw_done) state_reg <= S_CHECK;
                S_CHECK: begin
                    // A hit outranks the escape timeout when both land on the same check.
                    if ((mode_reg == M_FLY) && shot) begin
                        mode_reg  <= M_FALL;
                        state_reg <= S_WAIT;
                    end else if ((mode_reg == M_FLY) && esc_due) begin
                        mode_reg  <= M_FLEE;
                        state_reg <= S_WAIT;
                    end else if ((mode_reg != M_FLY) && !flying) begin
                        state_reg <= S_DONE;
                    end else begin
                        state_reg <= S_WAIT;
                        if (mode_reg == M_FLY) begin
                            if (dirc_reg == DIRC_W'(DIR_HOLD_FRAMES - 1)) begin
                                dirc_reg <= '0;
                                dir_reg  <= lfsr_reg[1:0];
                            end else begin
                                dirc_reg <= dirc_reg + 1'b1;
                            end
                        end
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        control = OP_HOLD;
        case (state_reg)
            S_DRAW0, S_DRAW: control = OP_DRAW;
            S_WAIT:          control = OP_PREHOLD;
            S_ERASE:         control = OP_CLEAR;
            S_CHECK:         control = OP_CHECK;
            S_MOVE: begin
                case (mode_reg)
                    M_FALL:  control = OP_SHOT;
                    M_FLEE:  control = OP_ESCAPE;
                    default: begin
                        case (dir_reg)
                            2'd0:    control = OP_LEFT;
                            2'd1:    control = OP_RIGHT;
                            2'd2:    control = OP_UP;
                            default: control = OP_DOWN;
                        endcase
                    end
                endcase
            end
            default:         control = OP_HOLD;
        endcase
    end

    assign active  = (state_reg != S_IDLE);
    assign hit     = (state_reg == S_DONE) && (mode_reg == M_FALL);
    assign escaped = (state_reg == S_DONE) && (mode_reg == M_FLEE);

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Randomized rounds against a frame-level reference; a forked monitor pops the
// expected move opcodes and end-of-round pulses from a scoreboard queue.
module tb_bird_motion_ctrl;
    localparam int         TD          = 64;
    localparam int         FSF         = 4;
    localparam int         DH          = 4;
    localparam int         ESC         = 40;
    localparam logic [7:0] SEED        = 8'hA5;
    localparam int         N_ROUNDS    = 12;
    localparam int         RESET_ROUND = 2;
    localparam int         MAX_ITER    = 90000;
    localparam int         EV_HIT      = 100;
    localparam int         EV_ESC      = 200;

    localparam int OP_HOLD = 0, OP_CLEAR = 5, OP_DRAW = 6, OP_SHOT = 7;
    localparam int OP_ESCAPE = 8, OP_CHECK = 9, OP_PREHOLD = 11;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       go;
    logic       draw_done;
    logic       shot;
    logic       flying;
    logic [3:0] control;
    logic       active;
    logic       hit;
    logic       escaped;

    int cyc;
    int errors = 0;
    int checks = 0;
    int exp_q[$];

    bird_motion_ctrl #(
        .TICK_DIV(TD), .FLY_STEP_FRAMES(FSF), .DIR_HOLD_FRAMES(DH),
        .ESCAPE_FRAMES(ESC), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .draw_done(draw_done),
        .shot(shot), .flying(flying), .control(control), .active(active),
        .hit(hit), .escaped(escaped)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; the frame divider equals cyc mod TD.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    // LFSR value seen during cycle n: seed advanced once per completed frame.
    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] v;
        v = SEED;
        for (int i = 0; i < n / TD; i++)
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic pop_cmp(input string name, input int got);
        int want;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d, expected no event (cycle %0d)", name, got, cyc);
        end else begin
            want = exp_q.pop_front();
            $display("txn %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
            check(name, got, want);
        end
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            #2;
            if (reset_n) begin
                if (control inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8})
                    pop_cmp("move_opcode", int'(control));
                if (hit)
                    pop_cmp("hit_pulse", EV_HIT);
                if (escaped)
                    pop_cmp("escaped_pulse", EV_ESC);
            end
        end
    endtask

    initial begin
        int n, op, lat, seg_cnt, fall_left, exp_next, idle_gap, bird_mode;
        int frames_acc, dir_checks, go_cyc, policy, shot_at, fly_checks, started, e, iter;
        bit pend, in_round, consume, first_draw, in_done, idle_chk, reset_done, want_shot;
        logic [1:0] dir;
        logic [7:0] lv;

        go = 1'b0; draw_done = 1'b0; shot = 1'b0; flying = 1'b0; reset_n = 1'b0;
        lat = 0; seg_cnt = 0; fall_left = 0; exp_next = -1; idle_gap = 3; bird_mode = 0;
        frames_acc = 0; dir_checks = 0; go_cyc = 0; policy = 0; shot_at = 0; fly_checks = 0;
        started = 0; iter = 0; pend = 0; in_round = 0; first_draw = 0; in_done = 0;
        idle_chk = 0; reset_done = 0; dir = '0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_control", int'(control), 0);
        check("reset_active", int'(active), 0);
        check("reset_hit", int'(hit), 0);
        check("reset_escaped", int'(escaped), 0);
        reset_n = 1'b1;

        while (!(started >= N_ROUNDS && !in_round)) begin
            @(negedge clk);
            iter++;
            if (iter > MAX_ITER) begin
                checks++;
                errors++;
                $display("FAIL cycle_budget: got %0d cycles, expected at most %0d", iter, MAX_ITER);
                break;
            end
            n  = cyc;
            op = int'(control);
            if (exp_next >= 0) begin
                check("next_control", op, exp_next);
                exp_next = -1;
            end
            if (idle_chk) begin
                check("idle_active", int'(active), 0);
                idle_chk = 0;
            end
            consume = 0;
            go      = 1'b0;
            shot    = 1'($urandom);

            // Asynchronous reset in the middle of the first erase of one round.
            if (!reset_done && started == RESET_ROUND && op == OP_CLEAR) begin
                reset_n = 1'b0;
                #1;
                check("midreset_control", int'(control), 0);
                check("midreset_active", int'(active), 0);
                @(negedge clk);
                reset_n = 1'b1;
                pend = 0; in_round = 0; exp_q.delete(); exp_next = -1; fall_left = 0;
                flying = 1'b0; seg_cnt = 0; in_done = 0; idle_gap = 0; reset_done = 1;
                draw_done = 1'b0;
                continue;
            end

            // Round start / end bookkeeping.
            if (in_done) begin
                in_done = 0; in_round = 0; exp_next = OP_HOLD; idle_chk = 1;
                idle_gap = $urandom_range(0, 40);
            end else if (!in_round && op == OP_HOLD && !active) begin
                if (idle_gap > 0) begin
                    idle_gap--;
                end else if (started < N_ROUNDS) begin
                    go = 1'b1; in_round = 1; started++; go_cyc = n; bird_mode = 0;
                    frames_acc = 0; dir_checks = 0; fly_checks = 0; first_draw = 1;
                    lv = lfsr_at(n);
                    dir = lv[1:0];
                    exp_q.push_back(1 + int'(dir));
                    exp_next = OP_DRAW;
                    policy  = $urandom_range(0, 2);
                    shot_at = $urandom_range(1, 8);
                end
            end else if (active) begin
                go = 1'($urandom);
            end

            // Datapath model: sprite clear/draw completes lat cycles after entry.
            if (op == OP_CLEAR || op == OP_DRAW) begin
                seg_cnt++;
                if (seg_cnt == 1)
                    lat = ($urandom_range(0, 15) == 0) ? 140 : $urandom_range(2, 24);
                draw_done = (seg_cnt == lat);
                if (in_round) begin
                    if (!draw_done) begin
                        exp_next = op;
                    end else if (op == OP_CLEAR) begin
                        if (exp_q.size() > 0) exp_next = exp_q[0];
                    end else begin
                        exp_next   = first_draw ? OP_PREHOLD : OP_CHECK;
                        first_draw = 0;
                    end
                end
            end else begin
                seg_cnt   = 0;
                draw_done = 1'($urandom);
            end

            if (op inside {1, 2, 3, 4, 7, 8}) begin
                if (in_round) exp_next = OP_DRAW;
                if ((op == OP_SHOT || op == OP_ESCAPE) && fall_left > 0) fall_left--;
                flying = (fall_left > 0);
            end

            // Frame pacing: a pending tick is consumed each waiting cycle.
            if (in_round && op == OP_PREHOLD) begin
                exp_next = OP_PREHOLD;
                if (pend) begin
                    consume = 1;
                    if (bird_mode != 0 || frames_acc == FSF - 1) begin
                        frames_acc = 0;
                        exp_next   = OP_CLEAR;
                    end else begin
                        frames_acc++;
                    end
                end
            end

            if (in_round && op == OP_CHECK) begin
                e = n / TD - (go_cyc + 1) / TD;
                exp_next = OP_PREHOLD;
                if (bird_mode == 0) begin
                    fly_checks++;
                    want_shot = (policy == 1 && fly_checks == shot_at) || (policy == 2 && e >= ESC);
                    shot = want_shot;
                    if (want_shot) begin
                        bird_mode = 1;
                        fall_left = $urandom_range(1, 4);
                        exp_q.push_back(OP_SHOT);
                    end else if (e >= ESC) begin
                        bird_mode = 2;
                        fall_left = $urandom_range(1, 4);
                        exp_q.push_back(OP_ESCAPE);
                    end else begin
                        dir_checks++;
                        if (dir_checks == DH) begin
                            dir_checks = 0;
                            lv  = lfsr_at(n);
                            dir = lv[1:0];
                        end
                        exp_q.push_back(1 + int'(dir));
                    end
                end else if (!flying) begin
                    exp_q.push_back(bird_mode == 1 ? EV_HIT : EV_ESC);
                    exp_next = OP_HOLD;
                    in_done  = 1;
                end else begin
                    exp_q.push_back(bird_mode == 1 ? OP_SHOT : OP_ESCAPE);
                end
            end

            pend = consume ? 1'b0 : (pend || (n % TD == TD - 1));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bird_motion_ctrl.md
# bird_motion_ctrl

Sequencing FSM for the bird sprite datapath. Drives the datapath's 4-bit `control` opcode through the draw, erase, move and check cycle once per frame. Runs each round through three phases: normal flight in a pseudo-random direction, a fall after a hit, and an escape after a timeout. Sits between the game top level (`go`, `hit`, `escaped`) and the bird datapath (`draw_done`, `shot`, `flying`).

## Interface
- `TICK_DIV`, 833333, clk cycles per frame tick (60 Hz at 50 MHz); minimum 64.
- `FLY_STEP_FRAMES`, 4, frames per one-pixel move in fly mode.
- `DIR_HOLD_FRAMES`, 32, fly-mode moves between direction re-draws.
- `ESCAPE_FRAMES`, 600, frames of flight before the bird flees.
- `LFSR_SEED`, 8'hA5, nonzero LFSR reset value.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `go`  in  1  start a round; sampled only in IDLE.
- `draw_done`  in  1  datapath "enable": sprite clear or draw finished.
- `shot`  in  1  datapath hit flag.
- `flying`  in  1  datapath fall or escape in progress.
- `control`  out  4  datapath opcode.
- `active`  out  1  round in progress.
- `hit`  out  1  one-cycle pulse when a fall completes.
- `escaped`  out  1  one-cycle pulse when an escape completes.

## Operation
Opcodes: HOLD 0, LEFT 1, RIGHT 2, UP 3, DOWN 4, CLEAR 5, DRAW 6, SHOT 7, ESCAPE 8, CHECK 9, PREHOLD 11.

Registers: `state`, `mode` {FLY, FALL, FLEE}, `dir[1:0]`, frame divider, step counter, direction counter, escape frame counter, 8-bit Fibonacci LFSR (taps 8,6,5,4), `tick_pend`.

`control` is decoded combinationally from `state` and `mode`. States and their opcodes:
- IDLE (HOLD): `active`=0. When `go`=1: set mode=FLY, clear all counters, load `dir` from `lfsr[1:0]`, go to DRAW0.
- DRAW0 (DRAW): exit to WAIT on the first cycle `draw_done`=1.
- WAIT (PREHOLD): exit to ERASE when `tick_pend`=1 and either mode≠FLY or the step counter has reached `FLY_STEP_FRAMES`-1.
  - On a tick that does not cause a step, increment the step counter.
  - Consuming a tick clears `tick_pend`.
  - A step resets the step counter.
- ERASE (CLEAR): exit to MOVE on `draw_done`=1.
- MOVE (one cycle). Opcode depends on mode:
  - FLY: `dir` 0/1/2/3 maps to LEFT/RIGHT/UP/DOWN.
  - FALL: SHOT.
  - FLEE: ESCAPE.
  - Next state DRAW.
- DRAW (DRAW): exit to CHECK on `draw_done`=1.
- CHECK (CHECK, one cycle). First matching rule wins:
  1. mode=FLY and `shot`=1: mode:=FALL, go to WAIT.
  2. mode=FLY and escape counter ≥ `ESCAPE_FRAMES`: mode:=FLEE, go to WAIT.
  3. mode≠FLY and `flying`=0: go to DONE.
  4. Otherwise go to WAIT. In FLY mode, increment the direction counter; when it reaches `DIR_HOLD_FRAMES`, reset it and reload `dir` from `lfsr[1:0]`.
- DONE (HOLD, one cycle): pulse `hit` if mode=FALL, `escaped` if mode=FLEE; go to IDLE.

Frame tick and shared counters:
- Frame divider counts 0..`TICK_DIV`-1 continuously, including in IDLE; the tick fires on wrap.
- A tick sets `tick_pend`. Ticks that arrive while `tick_pend` is already set are dropped, not queued.
- LFSR advances on every tick.
- Escape counter increments on each tick while mode=FLY and state≠IDLE; it saturates.
- `active`=1 in every state except IDLE.

## Timing
- Reset (asynchronous, any state):
  - State: IDLE, mode=FLY, `control`=0, `active`=0, `hit`=0, `escaped`=0.
  - Registers: all counters 0, `tick_pend`=0, `dir`=0, LFSR=`LFSR_SEED`.
- A reset mid-draw abandons the sprite. The datapath resets at the same time.
- `go` to `control`=DRAW: 1 cycle.
- `draw_done` is sampled at the clock edge. `control` changes at the same edge that sees `draw_done`=1, so DRAW/CLEAR is held until that edge.
- MOVE and CHECK last exactly 1 cycle each.
- `flying` is evaluated in CHECK, at least 2 cycles after the SHOT/ESCAPE cycle, so the datapath's registered update is visible.
- `go` outside IDLE: ignored.
- `draw_done` outside DRAW0/ERASE/DRAW: ignored.
- `shot` outside CHECK: ignored.
- `shot` and escape timeout in the same CHECK: the hit wins.
- Frame pacing: one step per `FLY_STEP_FRAMES` frames in FLY mode; one step per frame in FALL and FLEE modes.

## Test plan
- Reset mid-ERASE → on the next cycle `control`=0 and `active`=0. Then `go` → `control`=6 one cycle later.
- FLY stepping (`TICK_DIV`=64, `FLY_STEP_FRAMES`=4, datapath model asserts `draw_done` 17 cycles after CLEAR/DRAW entry) → exactly one LEFT/RIGHT/UP/DOWN cycle per 256 clk cycles. The opcode matches `dir`, and `dir` changes only after 32 moves.
- `shot`=1 held during CHECK, then `flying` drops after 3 SHOT steps → mode FALL, exactly 3 opcode-7 cycles, `hit` high for 1 cycle, then `control`=0 and `active`=0.
- `ESCAPE_FRAMES`=8, `shot` never asserted → first CHECK at or after frame 8 enters FLEE. ESCAPE (8) is issued once per frame until `flying`=0, then `escaped` pulses once.
- `shot`=1 and escape counter = `ESCAPE_FRAMES` in the same CHECK → FALL path taken, `hit` pulses, `escaped` never pulses.
- Two ticks while in DRAW (`draw_done` withheld) → exactly one pending step is consumed once WAIT is reached.
